// File: rtl/sort_engine_pkg.sv
// sort_engine_pkg: shared definitions for the 8-entry bubble-sort engine.
//   state_e  : FSM states IDLE / LOAD / SORT / UNLOAD
//   N        : number of elements held by the engine
//   IDX_W    : width of the element index and pass counters
//   NUM_CMP  : compares per pass (N-1), also the number of passes
//   LAST_IDX : index of the final element (last load / last unload)
//   LAST_CMP : index of the final compare within a pass, and the final pass
package sort_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SORT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_e;

  localparam int N       = 8;
  localparam int IDX_W   = 3;
  localparam int NUM_CMP = 7;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;
  localparam logic [IDX_W-1:0] LAST_CMP = 3'd6;

endpackage

// File: rtl/sort_engine_cmp_swap.sv
// cmp_swap: combinational compare-and-swap of two unsigned elements.
//   a, b    : input pair, a is the lower-addressed element
//   lo, hi  : pair in ascending order
//   swapped : high when a > b; equal values are left in place
module cmp_swap #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  // Strict greater-than keeps equal elements in their original order.
  always_comb begin
    swapped = (a > b);
    if (swapped) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

// File: rtl/sort_engine.sv
// sort_engine: loads 8 unsigned elements, bubble-sorts them in place and
// unloads them in ascending order.
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   start     : begin a job (sampled only in IDLE)
//   in_valid  / in_data  / in_ready  : load handshake
//   out_valid / out_data / out_ready : unload handshake
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse after the last element is unloaded
// Optional feature: define SORT_EARLY_EXIT_EN to leave SORT after the first
// pass that performs no swap.
module sort_engine
  import sort_engine_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic             done_q, done_d;
  logic [W-1:0]     mem_q [N];
  logic [W-1:0]     mem_d [N];

  logic [IDX_W-1:0] idx_p1_s;
  logic [W-1:0]     lo_s, hi_s;
  logic             swap_s;

`ifdef SORT_EARLY_EXIT_EN
  logic             swapped_q, swapped_d;
  logic             pass_swapped_s;
`endif

  assign idx_p1_s = idx_q + 3'd1;

  cmp_swap #(.W(W)) u_cmp_swap (
    .a       (mem_q[idx_q]),
    .b       (mem_q[idx_p1_s]),
    .lo      (lo_s),
    .hi      (hi_s),
    .swapped (swap_s)
  );

  // State, counters, storage and done pulse register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      pass_q    <= 3'd0;
      done_q    <= 1'b0;
      mem_q     <= '{default: {W{1'b0}}};
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      mem_q     <= mem_d;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  // Next-state, counter and storage update logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
`ifdef SORT_EARLY_EXIT_EN
    swapped_d      = swapped_q;
    // The flag restarts at the first compare of every pass.
    pass_swapped_s = (idx_q == 3'd0) ? swap_s : (swapped_q | swap_s);
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mem_d[idx_q] = in_data;
          idx_d        = idx_p1_s;  // wraps to 0 after the last element
          if (idx_q == LAST_IDX) begin
            state_d = S_SORT;
            pass_d  = 3'd0;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_SORT: begin
        if (swap_s) begin
          mem_d[idx_q]    = lo_s;
          mem_d[idx_p1_s] = hi_s;
        end else begin
          mem_d[idx_q] = mem_q[idx_q];
        end
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = pass_swapped_s;
`endif
        if (idx_q == LAST_CMP) begin
          idx_d  = 3'd0;
          pass_d = pass_q + 3'd1;
`ifdef SORT_EARLY_EXIT_EN
          if ((pass_q == LAST_CMP) || !pass_swapped_s) begin
`else
          if (pass_q == LAST_CMP) begin
`endif
            state_d = S_UNLOAD;
          end else begin
            state_d = S_SORT;
          end
        end else begin
          idx_d = idx_p1_s;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          idx_d = idx_p1_s;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_UNLOAD;
          end
        end else begin
          state_d = S_UNLOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        pass_d  = 3'd0;
      end
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    out_valid = (state_q == S_UNLOAD);
    busy      = (state_q != S_IDLE);
    out_data  = mem_q[idx_q];
    done      = done_q;
  end

endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed-vector scoreboard bench for sort_engine.
// The driver pushes each job's hand-sorted result into exp_q; an independent
// monitor pops and compares on every output transfer and also checks that
// out_data holds while stalled and that in_ready/out_valid never overlap.
module tb_sort_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] vin  [6][8];
  logic [W-1:0] vout [6][8];

  sort_engine #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    logic         stall_prev;
    logic [W-1:0] data_prev;
    logic [W-1:0] e;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        check("ready_valid_excl", {31'd0, in_ready & out_valid}, 32'd0);
        if (stall_prev && out_valid === 1'b1)
          check("stall_hold", {24'd0, out_data}, {24'd0, data_prev});
        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0d expected no transfer", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", {24'd0, out_data}, {24'd0, e});
            pop_cnt++;
          end
        end
        stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
        data_prev  = out_data;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic do_start(input bit with_valid);
    @(posedge clk); #1;
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = 8'hEE;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("load_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_load(input int job, input bit start_mid);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vin[job][i];
      start    = start_mid && (i == 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("sort_in_ready", {31'd0, in_ready}, 32'd0);
    check("sort_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_job(input int job, input bit start_valid, input bit start_mid,
                         input bit toggle, input int exp_sort);
    int n;
    int cyc;
    int d0;
    int p0;
    logic [3:0] pat;
    pat = 4'b1001;
    d0  = done_cnt;
    p0  = pop_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(vout[job][i]);
    do_start(start_valid);
    run_load(job, start_mid);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (exp_sort >= 0) check("sort_cycles", n, exp_sort);
    check("unload_valid", {31'd0, out_valid}, 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      out_ready = toggle ? pat[cyc % 4] : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    if (!toggle) check("unload_cycles", cyc, 8);
    @(posedge clk); #1;
    check("done_cleared", {31'd0, done}, 32'd0);
    check("done_count", done_cnt - d0, 1);
    check("pop_count", pop_cnt - p0, 8);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin : driver
    int sort_full;
    int sort_c;
    int d0;
`ifdef SORT_EARLY_EXIT_EN
    sort_full = -1;
    sort_c    = 7;
`else
    sort_full = 49;
    sort_c    = 49;
`endif
    vin[0]  = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    vout[0] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vin[1]  = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
    vout[1] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    vin[2]  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vout[2] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    vin[3]  = '{8'd5, 8'd9, 8'd2, 8'd200, 8'd7, 8'd7, 8'd1, 8'd3};
    vout[3] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd7, 8'd9, 8'd200};
    vin[4]  = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80};
    vout[4] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    vin[5]  = '{8'd255, 8'd0, 8'd128, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    vout[5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd128, 8'd255};

    rst       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b1;

    run_job(0, 1'b0, 1'b0, 1'b0, 49);
    run_job(1, 1'b0, 1'b0, 1'b1, sort_full);
    run_job(2, 1'b0, 1'b0, 1'b0, sort_c);
    run_job(3, 1'b1, 1'b1, 1'b1, sort_full);

    // Abandon a job in SORT cycle 20.
    d0 = done_cnt;
    do_start(1'b0);
    run_load(4, 1'b0);
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("abort_in_sort", {30'd0, busy, out_valid}, 32'd2);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_mem_clear", {24'd0, out_data}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("abort_no_done", done_cnt - d0, 0);

    run_job(5, 1'b0, 1'b0, 1'b0, sort_full);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sort_engine.md
SORT_ENGINE -- requirements
Module: sort_engine

Interface
REQ-001 W, default 8: unsigned element width in bits.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 rst  input  1  reset, synchronous, active-low: sampled on rising clk, asserted when 0.
REQ-004 start  input  1  begin a job; sampled only in IDLE.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_data  input  W  element being loaded.
REQ-007 in_ready  output  1  engine accepts in_data this cycle.
REQ-008 out_valid  output  1  out_data holds a sorted element.
REQ-009 out_data  output  W  sorted element, ascending order.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the last element is unloaded.

Function
REQ-013 The block SHALL hold 8 elements in an internal array mem[0..7], addressed by a 3-bit index counter idx and sequenced by a 3-bit pass counter pass.
REQ-014 The FSM SHALL have states IDLE, LOAD, SORT and UNLOAD.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 SHALL go to LOAD with idx=0; in_valid in IDLE SHALL be ignored, even when it coincides with start.
REQ-016 LOAD: in_ready=1; each in_valid&&in_ready SHALL write mem[idx] and increment idx; the transfer at idx=7 SHALL wrap idx to 0, clear pass and go to SORT.
REQ-017 SORT: each cycle SHALL compare mem[idx] and mem[idx+1] as unsigned values and swap them when mem[idx] > mem[idx+1]; equal values SHALL NOT swap.
REQ-018 SORT: idx SHALL advance 0..6; at idx=6, idx SHALL return to 0 and pass SHALL increment; the compare at pass=6, idx=6 SHALL be followed by UNLOAD with idx=0.
REQ-019 Sort latency without early exit SHALL be exactly 49 cycles (7 passes x 7 compares).
REQ-020 UNLOAD: out_valid=1 and out_data=mem[idx]; each out_valid&&out_ready SHALL increment idx; out_data SHALL hold stable while out_ready=0.
REQ-021 The transfer at idx=7 SHALL go to IDLE and assert done for exactly the next cycle.
REQ-022 start SHALL be ignored in LOAD, SORT and UNLOAD.
REQ-023 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-024 rst=0 SHALL, at the next clk edge, force IDLE, idx=0, pass=0, in_ready=0, out_valid=0, done=0, busy=0 and clear all of mem to zero, from any state.
REQ-025 A reset mid-job SHALL abandon the job with no done pulse and no further output transfer.

Configuration
REQ-026 Macro SORT_EARLY_EXIT_EN: when defined, a swapped flag SHALL clear at idx=0 of each pass; a pass that completes with no swap SHALL go directly to UNLOAD.
REQ-027 Without SORT_EARLY_EXIT_EN, every job SHALL take the full 49 SORT cycles regardless of the data.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, N=8, the index width of 3, and the compare count of 7.
REQ-029 A combinational sub-module cmp_swap (inputs a, b; outputs lo, hi, swapped) SHALL implement the compare-and-swap.

Verification
REQ-030 Load 7,6,5,4,3,2,1,0 with out_ready=1 -> unload 0..7; SORT lasts 49 cycles; done pulses once.
REQ-031 Load 3,3,1,1,2,2,0,0 -> unload 0,0,1,1,2,2,3,3; equal values are never swapped.
REQ-032 Load 0..7 already sorted with SORT_EARLY_EXIT_EN defined -> UNLOAD entered after 7 SORT cycles; without the macro -> 49 cycles.
REQ-033 Toggle out_ready 1,0,0,1 during UNLOAD -> out_data held stable while stalled; all 8 elements delivered once, in order.
REQ-034 Assert rst=0 at SORT cycle 20 -> next cycle IDLE, busy=0, no done; a following job with 255,0,128,1,0,0,0,0 (W=8) -> unload 0,0,0,0,0,1,128,255.
REQ-035 Assert start and in_valid together in IDLE, then start again during LOAD -> first in_valid ignored; the second start has no effect; exactly 8 elements are loaded.
